udp_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the single UDP TX header+payload interface of host_stack/fpga_core between N requesters, e.g. the ACK/NACK generator and the data sender.
- A grant is taken per UDP datagram and held from the header handshake through the payload beat carrying tlast.
- Headers and payload are therefore never interleaved between requesters.
- Sits between the lego-protocol engines and the s_udp_hdr_* / s_udp_payload_axis_* inputs of the UDP stack.

---
 rtl/udp_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - packet-level round-robin arbiter for the UDP TX header+payload interface
// Optional: define UDP_TX_ARB_ACK_PRIO_EN to give port 0 strict priority at every IDLE arbitration.
module udp_tx_arbiter #(
   parameter int PORTS      = 2,
   parameter int HDR_WIDTH  = 112,
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS*HDR_WIDTH-1:0]    s_udp_hdr_data,
   input  logic [PORTS-1:0]              s_udp_hdr_valid,
   output logic [PORTS-1:0]              s_udp_hdr_ready,
   input  logic [PORTS*DATA_WIDTH-1:0]   s_udp_payload_axis_tdata,
   input  logic [PORTS*KEEP_WIDTH-1:0]   s_udp_payload_axis_tkeep,
   input  logic [PORTS-1:0]              s_udp_payload_axis_tvalid,
   output logic [PORTS-1:0]              s_udp_payload_axis_tready,
   input  logic [PORTS-1:0]              s_udp_payload_axis_tlast,
   input  logic [PORTS-1:0]              s_udp_payload_axis_tuser,
   output logic [HDR_WIDTH-1:0]          m_udp_hdr_data,
   output logic                          m_udp_hdr_valid,
   input  logic                          m_udp_hdr_ready,
   output logic [DATA_WIDTH-1:0]         m_udp_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_udp_payload_axis_tkeep,
   output logic                          m_udp_payload_axis_tvalid,
   input  logic                          m_udp_payload_axis_tready,
   output logic                          m_udp_payload_axis_tlast,
   output logic                          m_udp_payload_axis_tuser,
   output logic [PORTS-1:0]              grant,
   output logic                          busy,
   output logic [31:0]                   pkt_count
);

   localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

`ifdef UDP_TX_ARB_ACK_PRIO_EN
   localparam bit ACK_PRIO = 1'b1;
`else
   localparam bit ACK_PRIO = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] grant_idx;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] cand;
   logic          win_found;
   logic          hdr_fire;
   logic          last_fire;

   // Pick the next owner: first valid header after last_grant (port 0 first when ACK priority is on)
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = '0;
      if (ACK_PRIO && s_udp_hdr_valid[0]) begin
         win_found = 1'b1;
      end else begin
         for (int k = 1; k <= PORTS; k++) begin
            cand = IW'((int'(last_grant) + k) % PORTS);
            if (!win_found && s_udp_hdr_valid[cand] && (!ACK_PRIO || cand != '0)) begin
               win_idx   = cand;
               win_found = 1'b1;
            end
         end
      end
   end

   // Route the owner's header/payload to the stack and its readies back; everything else is held off
   always_comb begin
      m_udp_hdr_data            = s_udp_hdr_data[int'(grant_idx)*HDR_WIDTH +: HDR_WIDTH];
      m_udp_payload_axis_tdata  = s_udp_payload_axis_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      m_udp_payload_axis_tkeep  = s_udp_payload_axis_tkeep[int'(grant_idx)*KEEP_WIDTH +: KEEP_WIDTH];
      m_udp_hdr_valid           = 1'b0;
      m_udp_payload_axis_tvalid = 1'b0;
      m_udp_payload_axis_tlast  = 1'b0;
      m_udp_payload_axis_tuser  = 1'b0;
      s_udp_hdr_ready           = '0;
      s_udp_payload_axis_tready = '0;
      grant                     = '0;
      busy                      = 1'b0;
      case (state)
         HDR: begin
            grant           = {{(PORTS-1){1'b0}}, 1'b1} << grant_idx;
            busy            = 1'b1;
            m_udp_hdr_valid = s_udp_hdr_valid[grant_idx];
            s_udp_hdr_ready = grant & {PORTS{m_udp_hdr_ready}};
         end
         PAYLOAD: begin
            grant                     = {{(PORTS-1){1'b0}}, 1'b1} << grant_idx;
            busy                      = 1'b1;
            m_udp_payload_axis_tvalid = s_udp_payload_axis_tvalid[grant_idx];
            m_udp_payload_axis_tlast  = s_udp_payload_axis_tlast[grant_idx];
            m_udp_payload_axis_tuser  = s_udp_payload_axis_tuser[grant_idx];
            s_udp_payload_axis_tready = grant & {PORTS{m_udp_payload_axis_tready}};
         end
         default: begin
         end
      endcase
   end

   assign hdr_fire  = m_udp_hdr_valid && m_udp_hdr_ready;
   assign last_fire = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready && m_udp_payload_axis_tlast;

   // Next state: grant held from header handshake through the tlast beat
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (win_found) state_next = HDR;
         HDR:     if (hdr_fire)  state_next = PAYLOAD;
         PAYLOAD: if (last_fire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Register the winner at arbitration; last_grant starts at PORTS-1 so port 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_idx  <= '0;
         last_grant <= IW'(PORTS - 1);
      end else if (state == IDLE && win_found) begin
         grant_idx  <= win_idx;
         last_grant <= win_idx;
      end
   end

   // Count completed datagrams at the tlast handshake (free-running wrap)
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            pkt_count <= '0;
      else if (last_fire) pkt_count <= pkt_count + 32'd1;
   end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - directed self-checking bench for udp_tx_arbiter
module tb_udp_tx_arbiter;

   localparam int P  = 2;
   localparam int HW = 112;
   localparam int DW = 64;
   localparam int KW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [P*HW-1:0] s_hdr_data;
   logic [P-1:0]    s_hdr_valid;
   logic [P-1:0]    s_hdr_ready;
   logic [P*DW-1:0] s_tdata;
   logic [P*KW-1:0] s_tkeep;
   logic [P-1:0]    s_tvalid;
   logic [P-1:0]    s_tready;
   logic [P-1:0]    s_tlast;
   logic [P-1:0]    s_tuser;
   logic [HW-1:0]   m_hdr_data;
   logic            m_hdr_valid;
   logic            m_hdr_ready = 1'b1;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tvalid;
   logic            m_tready = 1'b1;
   logic            m_tlast;
   logic            m_tuser;
   logic [P-1:0]    grant;
   logic            busy;
   logic [31:0]     pkt_count;

   logic [HW-1:0] hdr_d [P];
   logic          hdr_v [P];
   logic [DW-1:0] pay_d [P];
   logic          pay_v [P];
   logic          pay_l [P];
   logic          pay_u [P];

   int vectors     = 0;
   int miscompares = 0;
   int proto_err   = 0;

   logic [HW-1:0] hdr_q [$];
   logic [DW-1:0] beat_q [$];
   logic          last_q [$];

   always #5 clk = ~clk;

   udp_tx_arbiter #(.PORTS(P), .HDR_WIDTH(HW), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
      .clk(clk), .rst(rst),
      .s_udp_hdr_data(s_hdr_data), .s_udp_hdr_valid(s_hdr_valid), .s_udp_hdr_ready(s_hdr_ready),
      .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tkeep(s_tkeep),
      .s_udp_payload_axis_tvalid(s_tvalid), .s_udp_payload_axis_tready(s_tready),
      .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
      .m_udp_hdr_data(m_hdr_data), .m_udp_hdr_valid(m_hdr_valid), .m_udp_hdr_ready(m_hdr_ready),
      .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
      .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
      .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser),
      .grant(grant), .busy(busy), .pkt_count(pkt_count)
   );

   // Pack per-port requester state onto the DUT buses
   always_comb begin
      for (int p = 0; p < P; p++) begin
         s_hdr_data[p*HW +: HW] = hdr_d[p];
         s_hdr_valid[p]         = hdr_v[p];
         s_tdata[p*DW +: DW]    = pay_d[p];
         s_tkeep[p*KW +: KW]    = {KW{1'b1}};
         s_tvalid[p]            = pay_v[p];
         s_tlast[p]             = pay_l[p];
         s_tuser[p]             = pay_u[p];
      end
   end

   // Log stack-side handshakes and flag any ready leaking to a non-owner
   always @(negedge clk) begin
      if (!rst) begin
         if (m_hdr_valid && m_hdr_ready) hdr_q.push_back(m_hdr_data);
         if (m_tvalid && m_tready) begin
            beat_q.push_back(m_tdata);
            last_q.push_back(m_tlast);
         end
         if (((s_hdr_ready | s_tready) & ~grant) != '0 || (m_tvalid && s_hdr_ready != '0) ||
             (m_hdr_valid && s_tready != '0))
            proto_err++;
      end
   end

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [HW-1:0] mk_hdr(input int p, input int k);
      return {16'd24, 16'(1234 + k), 16'(1000 + p), 32'hC0A8_0180, 32'hC0A8_0181};
   endfunction

   function automatic logic [DW-1:0] beat_val(input int p, input int k, input int b);
      return {8'hB0, 8'(p), 8'(k), 40'(b)};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      for (int p = 0; p < P; p++) begin
         hdr_d[p] = '0; hdr_v[p] = 1'b0; pay_d[p] = '0;
         pay_v[p] = 1'b0; pay_l[p] = 1'b0; pay_u[p] = 1'b0;
      end
      m_hdr_ready = 1'b1;
      m_tready    = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drive_pkt(input int p, input int k, input int nb);
      bit ok;
      hdr_d[p] = mk_hdr(p, k);
      hdr_v[p] = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         ok = s_hdr_ready[p];
         step();
      end
      hdr_v[p] = 1'b0;
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL hdr_timeout port %0d pkt %0d: no handshake within 300 cycles", p, k);
      end
      for (int b = 0; b < nb; b++) begin
         pay_d[p] = beat_val(p, k, b);
         pay_v[p] = 1'b1;
         pay_l[p] = (b == nb - 1);
         ok = 1'b0;
         for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = s_tready[p];
            step();
         end
         if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL beat_timeout port %0d pkt %0d beat %0d", p, k, b);
         end
      end
      pay_v[p] = 1'b0;
      pay_l[p] = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      rst = 1'b1;
      #1;
      vectors++;
      if ({grant, busy, pkt_count} !== {2'b00, 1'b0, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_state: grant=%b busy=%b pkt_count=%0d, want 00/0/0", grant, busy, pkt_count);
      end
      vectors++;
      if ({m_hdr_valid, m_tvalid, s_hdr_ready, s_tready} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_handshake: mh=%b mp=%b sh=%b sp=%b, want all 0", m_hdr_valid, m_tvalid, s_hdr_ready, s_tready);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_single;
      logic [DW-1:0] beats [3];
      beats[0] = 64'h0300_0000_0000_0001;
      beats[1] = 64'h0f0f_0f0f_0f0f_0f0f;
      beats[2] = 64'h0101_0101_0101_0101;
      do_reset();
      hdr_d[0] = mk_hdr(0, 0);
      hdr_v[0] = 1'b1;
      #1;
      vectors++;
      if (m_hdr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_bubble: m_hdr_valid=%b, want 0 in request cycle", m_hdr_valid);
      end
      step();
      vectors++;
      if ({m_hdr_valid, grant, s_hdr_ready, busy} !== {1'b1, 2'b01, 2'b01, 1'b1}) begin
         miscompares++;
         $display("FAIL single_hdr: valid=%b grant=%b hrdy=%b busy=%b, want 1/01/01/1", m_hdr_valid, grant, s_hdr_ready, busy);
      end
      vectors++;
      if (m_hdr_data !== 112'h0018_04D2_03E8_C0A80180_C0A80181) begin
         miscompares++;
         $display("FAIL single_hdr_data: got %h want 001804d203e8c0a80180c0a80181", m_hdr_data);
      end
      pay_d[0] = beats[0];
      pay_v[0] = 1'b1;
      #1;
      vectors++;
      if ({s_tready, m_tvalid} !== 3'b000) begin
         miscompares++;
         $display("FAIL single_pay_stall: s_tready=%b m_tvalid=%b, want 00/0", s_tready, m_tvalid);
      end
      step();
      hdr_v[0] = 1'b0;
      for (int b = 0; b < 3; b++) begin
         pay_d[0] = beats[b];
         pay_l[0] = (b == 2);
         #1;
         vectors++;
         if ({m_tvalid, m_tlast, m_tdata, m_tkeep, grant} !== {1'b1, (b == 2), beats[b], 8'hFF, 2'b01}) begin
            miscompares++;
            $display("FAIL single_beat%0d: v=%b l=%b d=%h k=%h g=%b, want 1/%0d/%h/ff/01", b, m_tvalid, m_tlast, m_tdata, m_tkeep, grant, (b == 2), beats[b]);
         end
         step();
      end
      pay_v[0] = 1'b0;
      pay_l[0] = 1'b0;
      vectors++;
      if ({pkt_count, grant, busy} !== {32'd1, 2'b00, 1'b0}) begin
         miscompares++;
         $display("FAIL single_done: pkt_count=%0d grant=%b busy=%b, want 1/00/0", pkt_count, grant, busy);
      end
   endtask

   task automatic test_back_to_back;
      int pe0;
      do_reset();
      hdr_q.delete(); beat_q.delete(); last_q.delete();
      pe0 = proto_err;
      fork
         begin for (int k = 0; k < 4; k++) drive_pkt(0, k, 3); end
         begin for (int k = 0; k < 4; k++) drive_pkt(1, k, 3); end
      join
      step();
      vectors++;
      if (hdr_q.size() != 8 || beat_q.size() != 24) begin
         miscompares++;
         $display("FAIL b2b_counts: hdrs=%0d beats=%0d, want 8/24", hdr_q.size(), beat_q.size());
      end
      for (int i = 0; i < 8 && i < hdr_q.size(); i++) begin
         vectors++;
         if (hdr_q[i] !== mk_hdr(i % 2, i / 2)) begin
            miscompares++;
            $display("FAIL b2b_hdr%0d: got %h want %h", i, hdr_q[i], mk_hdr(i % 2, i / 2));
         end
      end
      for (int i = 0; i < 24 && i < beat_q.size(); i++) begin
         vectors++;
         if ({beat_q[i], last_q[i]} !== {beat_val((i / 3) % 2, i / 6, i % 3), (i % 3 == 2)}) begin
            miscompares++;
            $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, beat_q[i], last_q[i], beat_val((i / 3) % 2, i / 6, i % 3), (i % 3 == 2));
         end
      end
      vectors++;
      if (pkt_count !== 32'd8 || proto_err != pe0) begin
         miscompares++;
         $display("FAIL b2b_final: pkt_count=%0d proto_errs=%0d, want 8/0", pkt_count, proto_err - pe0);
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] pat;
      int pe0;
      pat = 16'hB269;
      do_reset();
      hdr_q.delete(); beat_q.delete(); last_q.delete();
      pe0 = proto_err;
      fork
         drive_pkt(0, 5, 3);
         drive_pkt(1, 5, 3);
         begin
            for (int c = 0; c < 60; c++) begin
               m_tready = pat[c % 16];
               step();
            end
            m_tready = 1'b1;
         end
      join
      vectors++;
      if (beat_q.size() != 6) begin
         miscompares++;
         $display("FAIL bp_count: beats=%0d want 6", beat_q.size());
      end
      for (int i = 0; i < 6 && i < beat_q.size(); i++) begin
         vectors++;
         if ({beat_q[i], last_q[i]} !== {beat_val(i / 3, 5, i % 3), (i % 3 == 2)}) begin
            miscompares++;
            $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, beat_q[i], last_q[i], beat_val(i / 3, 5, i % 3), (i % 3 == 2));
         end
      end
      vectors++;
      if (proto_err != pe0 || pkt_count !== 32'd2) begin
         miscompares++;
         $display("FAIL bp_stall: proto_errs=%0d pkt_count=%0d, want 0/2", proto_err - pe0, pkt_count);
      end
   endtask

   task automatic test_early_payload;
      do_reset();
      pay_d[1] = 64'hDEAD_BEEF_0000_0001;
      pay_v[1] = 1'b1;
      pay_l[1] = 1'b1;
      pay_u[1] = 1'b1;
      step();
      step();
      vectors++;
      if ({s_tready, m_tvalid, busy} !== 4'b0000) begin
         miscompares++;
         $display("FAIL early_idle: s_tready=%b m_tvalid=%b busy=%b, want 00/0/0", s_tready, m_tvalid, busy);
      end
      hdr_d[1] = mk_hdr(1, 9);
      hdr_v[1] = 1'b1;
      m_hdr_ready = 1'b0;
      step();
      vectors++;
      if ({grant, m_hdr_valid, s_hdr_ready, s_tready} !== {2'b10, 1'b1, 2'b00, 2'b00}) begin
         miscompares++;
         $display("FAIL early_hdr_wait: g=%b mh=%b hr=%b pr=%b, want 10/1/00/00", grant, m_hdr_valid, s_hdr_ready, s_tready);
      end
      m_hdr_ready = 1'b1;
      #1;
      vectors++;
      if ({s_hdr_ready, s_tready} !== 4'b1000) begin
         miscompares++;
         $display("FAIL early_hdr_rdy: hr=%b pr=%b, want 10/00", s_hdr_ready, s_tready);
      end
      step();
      hdr_v[1] = 1'b0;
      #1;
      vectors++;
      if ({s_tready, m_tvalid, m_tlast, m_tuser, m_tdata} !== {2'b10, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001}) begin
         miscompares++;
         $display("FAIL early_payload: pr=%b v=%b l=%b u=%b d=%h, want 10/1/1/1/deadbeef00000001", s_tready, m_tvalid, m_tlast, m_tuser, m_tdata);
      end
      step();
      pay_v[1] = 1'b0; pay_l[1] = 1'b0; pay_u[1] = 1'b0;
      vectors++;
      if ({busy, grant, pkt_count} !== {1'b0, 2'b00, 32'd1}) begin
         miscompares++;
         $display("FAIL early_done: busy=%b grant=%b pkt_count=%0d, want 0/00/1", busy, grant, pkt_count);
      end
   endtask

   task automatic test_reset_mid_packet;
      do_reset();
      hdr_d[0] = mk_hdr(0, 3);
      hdr_v[0] = 1'b1;
      step();
      step();
      hdr_v[0] = 1'b0;
      pay_d[0] = beat_val(0, 3, 0);
      pay_v[0] = 1'b1;
      step();
      pay_d[0] = beat_val(0, 3, 1);
      #1;
      vectors++;
      if ({m_tvalid, s_tready} !== 3'b101) begin
         miscompares++;
         $display("FAIL rstmid_beat2: m_tvalid=%b s_tready=%b, want 1/01", m_tvalid, s_tready);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({m_tvalid, m_hdr_valid, s_tready, s_hdr_ready, grant, busy, pkt_count} !== 40'd0) begin
         miscompares++;
         $display("FAIL rstmid_async: mp=%b mh=%b pr=%b hr=%b g=%b busy=%b cnt=%0d, want all 0", m_tvalid, m_hdr_valid, s_tready, s_hdr_ready, grant, busy, pkt_count);
      end
      step();
      pay_v[0] = 1'b0;
      rst = 1'b0;
      hdr_d[0] = mk_hdr(0, 4); hdr_v[0] = 1'b1;
      hdr_d[1] = mk_hdr(1, 4); hdr_v[1] = 1'b1;
      step();
      vectors++;
      if ({grant, pkt_count} !== {2'b01, 32'd0}) begin
         miscompares++;
         $display("FAIL rstmid_first_grant: grant=%b pkt_count=%0d, want 01/0", grant, pkt_count);
      end
      do_reset();
   endtask

   task automatic test_ack_priority;
      logic [HW-1:0] exp [6];
      exp[0] = mk_hdr(1, 0);
      exp[1] = mk_hdr(0, 0);
      exp[2] = mk_hdr(1, 1);
      exp[3] = mk_hdr(0, 1);
`ifdef UDP_TX_ARB_ACK_PRIO_EN
      exp[4] = mk_hdr(0, 2);
      exp[5] = mk_hdr(1, 2);
`else
      exp[4] = mk_hdr(1, 2);
      exp[5] = mk_hdr(0, 2);
`endif
      do_reset();
      hdr_q.delete(); beat_q.delete(); last_q.delete();
      fork
         begin drive_pkt(1, 0, 3); drive_pkt(1, 1, 3); end
         begin step(); step(); step(); drive_pkt(0, 0, 2); end
      join
      drive_pkt(0, 1, 1);
      fork
         drive_pkt(0, 2, 2);
         drive_pkt(1, 2, 2);
      join
      vectors++;
      if (hdr_q.size() != 6) begin
         miscompares++;
         $display("FAIL prio_count: hdrs=%0d want 6", hdr_q.size());
      end
      for (int i = 0; i < 6 && i < hdr_q.size(); i++) begin
         vectors++;
         if (hdr_q[i] !== exp[i]) begin
            miscompares++;
            $display("FAIL prio_order%0d: got %h want %h", i, hdr_q[i], exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_early_payload();
      test_reset_mid_packet();
      test_ack_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
